// File: rtl/chip_bridge_send_sched.sv
// chip_bridge_send_sched: round-robin, credit-gated scheduler serialising three 64-bit channels onto a 32-bit link
module chip_bridge_send_sched #(
  parameter int CREDITS = 8,
  parameter int CNT_W = 4
) (
  input  logic              chip_clk,
  input  logic              rst_n,
  input  logic [63:0]       network_out_1,
  input  logic [63:0]       network_out_2,
  input  logic [63:0]       network_out_3,
  input  logic              data_out_val_1,
  input  logic              data_out_val_2,
  input  logic              data_out_val_3,
  output logic              data_out_rdy_1,
  output logic              data_out_rdy_2,
  output logic              data_out_rdy_3,
  output logic [31:0]       intcnct_data_out,
  output logic [1:0]        intcnct_channel_out,
  input  logic [2:0]        intcnct_credit_back_out,
  output logic              credit_err
);
  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] credit [3];
  logic [1:0] ptr, sel, id;
  logic [63:0] flit;
  logic [2:0] val, elig, rdy, j;
  logic any, hs;
  assign val = {data_out_val_3, data_out_val_2, data_out_val_1};
  // pick the first eligible channel at or after the round-robin pointer
  always_comb begin
    elig = '0;
    any = 1'b0;
    sel = 2'd0;
    j = 3'd0;
    for (int k = 0; k < 3; k++) elig[k] = val[k] && (credit[k] != '0);
    for (int i = 2; i >= 0; i--) begin
      j = {1'b0, ptr} + 3'(i);
      if (j >= 3'd3) j = j - 3'd3;
      if (elig[j[1:0]]) begin
        any = 1'b1;
        sel = j[1:0];
      end
    end
  end
  assign hs = any && (state != SEND_HI);
  assign rdy = hs ? (3'b001 << sel) : 3'b000;
  assign {data_out_rdy_3, data_out_rdy_2, data_out_rdy_1} = rdy;
  // a handshake always starts a new flit; otherwise the high beat is followed by the low beat, then idle
  always_comb state_nx = hs ? SEND_HI : (state == SEND_HI ? SEND_LO : IDLE);
  // state, captured flit and round-robin pointer
  always_ff @(posedge chip_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      flit <= '0;
      id <= 2'd0;
      ptr <= 2'd0;
    end else begin
      state <= state_nx;
      if (hs) begin
        flit <= sel == 2'd0 ? network_out_1 : sel == 2'd1 ? network_out_2 : network_out_3;
        id <= sel + 2'd1;
        ptr <= sel == 2'd2 ? 2'd0 : sel + 2'd1;
      end
    end
  end
  // per-channel credits; a return and a send in the same cycle cancel out
  always_ff @(posedge chip_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) credit[k] <= CNT_W'(CREDITS);
      credit_err <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (intcnct_credit_back_out[k] && !(hs && sel == 2'(k))) begin
          if (credit[k] == CNT_W'(CREDITS)) credit_err <= 1'b1;
          else credit[k] <= credit[k] + CNT_W'(1);
        end else if (!intcnct_credit_back_out[k] && hs && sel == 2'(k)) begin
          credit[k] <= credit[k] - CNT_W'(1);
        end
      end
    end
  end
  assign intcnct_data_out = state == SEND_HI ? flit[63:32] : state == SEND_LO ? flit[31:0] : 32'd0;
  assign intcnct_channel_out = state == IDLE ? 2'b00 : id;
endmodule

// File: tb/tb_chip_bridge_send_sched.sv
// tb_chip_bridge_send_sched: directed scoreboard bench for the send scheduler
module tb_chip_bridge_send_sched;
  logic chip_clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] n1 = 64'h1111_2222_3333_4444;
  logic [63:0] n2 = 64'hAAAA_BBBB_CCCC_DDDD;
  logic [63:0] n3 = 64'h5555_6666_7777_8888;
  logic v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
  logic r1, r2, r3;
  logic [31:0] dout;
  logic [1:0] chan;
  logic [2:0] cb = 3'b000;
  logic err;
  int checks = 0, errors = 0, beats = 0;
  int hs [3] = '{0, 0, 0};
  int b0, h0, h1, h2;
  logic [33:0] q [$];
  logic [33:0] exp_b;
  always #5 chip_clk = ~chip_clk;
  chip_bridge_send_sched dut (
    .chip_clk(chip_clk),
    .rst_n(rst_n),
    .network_out_1(n1),
    .network_out_2(n2),
    .network_out_3(n3),
    .data_out_val_1(v1),
    .data_out_val_2(v2),
    .data_out_val_3(v3),
    .data_out_rdy_1(r1),
    .data_out_rdy_2(r2),
    .data_out_rdy_3(r3),
    .intcnct_data_out(dout),
    .intcnct_channel_out(chan),
    .intcnct_credit_back_out(cb),
    .credit_err(err)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge chip_clk);
    #1;
  endtask
  task automatic push_flit(input int c);
    logic [63:0] f;
    f = c == 1 ? n1 : c == 2 ? n2 : n3;
    q.push_back({2'(c), f[63:32]});
    q.push_back({2'(c), f[31:0]});
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    q.delete();
    tick;
    rst_n = 1'b1;
  endtask
  task automatic drain;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick;
    chk("drain", 64'(q.size()), 64'd0);
  endtask
  // scoreboard: every beat on the link must match the next expected beat
  always @(negedge chip_clk) if (rst_n) begin
    checks++;
    assert ($countones({r3, r2, r1}) <= 1) else begin
      errors++;
      $error("FAIL rdy_onehot: observed %b expected at most one bit", {r3, r2, r1});
    end
    if (v1 && r1) hs[0]++;
    if (v2 && r2) hs[1]++;
    if (v3 && r3) hs[2]++;
    if (chan != 2'b00) begin
      beats++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $error("FAIL beat_unexpected: observed %0h expected no beat", {chan, dout});
      end else begin
        exp_b = q.pop_front();
        assert ({chan, dout} === exp_b) else begin
          errors++;
          $error("FAIL beat: observed %0h expected %0h", {chan, dout}, exp_b);
        end
      end
    end
  end
  initial begin
    do_reset;
    @(negedge chip_clk);
    chk("rst_data", dout, 0);
    chk("rst_chan", chan, 0);
    chk("rst_rdy", {r3, r2, r1}, 0);
    chk("rst_err", err, 0);
    chk("rst_cr1", dut.credit[0], 8);
    chk("rst_cr2", dut.credit[1], 8);
    chk("rst_cr3", dut.credit[2], 8);
    v1 = 1'b1;
    push_flit(1);
    #1 chk("single_rdy1", r1, 1);
    tick;
    v1 = 1'b0;
    @(negedge chip_clk);
    chk("single_hi_chan", chan, 2'b01);
    chk("single_hi_data", dout, 32'h1111_2222);
    chk("single_rdy_drop", r1, 0);
    tick;
    @(negedge chip_clk);
    chk("single_lo_data", dout, 32'h3333_4444);
    tick;
    @(negedge chip_clk);
    chk("single_idle_chan", chan, 0);
    chk("single_idle_data", dout, 0);
    chk("single_cr1", dut.credit[0], 7);
    drain;
    do_reset;
    h0 = hs[0]; h1 = hs[1]; h2 = hs[2];
    {v1, v2, v3} = 3'b111;
    for (int i = 0; i < 2; i++) begin
      push_flit(1);
      push_flit(2);
      push_flit(3);
    end
    b0 = beats;
    repeat (11) tick;
    {v1, v2, v3} = 3'b000;
    tick;
    tick;
    chk("rr_contiguous", 64'(beats - b0), 12);
    chk("rr_hs1", 64'(hs[0] - h0), 2);
    chk("rr_hs2", 64'(hs[1] - h1), 2);
    chk("rr_hs3", 64'(hs[2] - h2), 2);
    drain;
    do_reset;
    h1 = hs[1];
    v2 = 1'b1;
    for (int i = 0; i < 8; i++) push_flit(2);
    repeat (20) tick;
    chk("exh_count", 64'(hs[1] - h1), 8);
    chk("exh_rdy2_low", r2, 0);
    cb = 3'b010;
    push_flit(2);
    @(negedge chip_clk);
    chk("exh_rdy2_pulse_cycle", r2, 0);
    tick;
    cb = 3'b000;
    @(negedge chip_clk);
    chk("exh_rdy2_after", r2, 1);
    tick;
    @(negedge chip_clk);
    chk("exh_beat_chan", chan, 2'b10);
    tick;
    tick;
    v2 = 1'b0;
    chk("exh_count_after", 64'(hs[1] - h1), 9);
    drain;
    do_reset;
    v2 = 1'b1;
    for (int i = 0; i < 4; i++) push_flit(2);
    repeat (6) tick;
    cb = 3'b010;
    tick;
    cb = 3'b000;
    v2 = 1'b0;
    chk("sim_cr2", dut.credit[1], 5);
    chk("sim_err", err, 0);
    drain;
    do_reset;
    cb = 3'b100;
    tick;
    cb = 3'b000;
    chk("ovf_cr3", dut.credit[2], 8);
    chk("ovf_err", err, 1);
    repeat (3) tick;
    chk("ovf_err_sticky", err, 1);
    v1 = 1'b1;
    q.push_back({2'd1, n1[63:32]});
    tick;
    v1 = 1'b0;
    @(negedge chip_clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_data", dout, 0);
    chk("midrst_chan", chan, 0);
    chk("midrst_err", err, 0);
    tick;
    rst_n = 1'b1;
    chk("midrst_cr1", dut.credit[0], 8);
    {v1, v2, v3} = 3'b111;
    push_flit(1);
    #1;
    chk("midrst_grant", {r3, r2, r1}, 3'b001);
    tick;
    {v1, v2, v3} = 3'b000;
    drain;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/chip_bridge_send_sched.md
Name: chip_bridge_send_sched

Overview:
- Transmit-side scheduler for the chip bridge.
- Shares the single 32-bit interconnect output among three 64-bit network channels using round-robin arbitration with per-channel credit flow control.
- Serialises each granted 64-bit flit into two 32-bit beats, high half first, tagged with a channel ID.
- Sits between the three on-chip network outputs and the interconnect pads, in the chip_clk domain.

Parameters:
- CREDITS, 8, initial and maximum credit count per channel (1..15); equals receiver buffer depth per channel.
- CNT_W, 4, width of each credit counter; must satisfy 2^CNT_W > CREDITS.

Ports:
- chip_clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- network_out_1  in  64  flit from network channel 1.
- network_out_2  in  64  flit from network channel 2.
- network_out_3  in  64  flit from network channel 3.
- data_out_val_1..3  in  1 each  flit valid, per channel.
- data_out_rdy_1..3  out  1 each  flit accepted this cycle when val&rdy, per channel.
- intcnct_data_out  out  32  serialised beat.
- intcnct_channel_out  out  2  beat tag: 2'b01/10/11 = channel 1/2/3; 2'b00 = idle.
- intcnct_credit_back_out  in  3  one-cycle credit-return pulses; bit k-1 is channel k.
- credit_err  out  1  sticky; set on a credit return while that counter is already at CREDITS.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; intcnct_data_out=0; intcnct_channel_out=2'b00.
  - All credit counters = CREDITS; RR pointer = channel 1; credit_err=0.
  - Any partially sent flit is dropped, with no recovery.
- States: IDLE, SEND_HI, SEND_LO. Outputs are registered and reflect the current state.
- Accept window: state is IDLE or SEND_LO.
- Eligibility: channel k is eligible when data_out_val_k=1 and credit_k>0 (registered counter value).
- Grant:
  - Pick the first eligible channel starting at the RR pointer, cyclic order 1->2->3->1.
  - data_out_rdy_k=1 only for the granted channel, and only in the accept window. Combinational from val, credits, state and pointer.
  - At most one rdy is high in any cycle.
- Handshake at edge t (val&rdy on channel k):
  - Latch the 64-bit flit and ID k.
  - credit_k decrements.
  - RR pointer advances to k+1 (3 wraps to 1).
  - Next state is SEND_HI.
- SEND_HI (cycle t+1): intcnct_data_out=flit[63:32], channel_out=k. Next state is SEND_LO unconditionally.
- SEND_LO (cycle t+2): intcnct_data_out=flit[31:0], channel_out=k.
  - A new handshake in this cycle goes to SEND_HI, giving back-to-back flits at 2 cycles/flit with no idle beat.
  - With no handshake, next state is IDLE: data_out=0, channel_out=00.
- Latency: handshake to first beat = 1 cycle.
- Credit return:
  - A credit_back_out[k-1] pulse increments credit_k at that edge.
  - Counters are independent; multiple bits may pulse in the same cycle.
- Simultaneous return and decrement on the same channel leaves the counter unchanged.
- Overflow: a return while at CREDITS (and no simultaneous decrement) holds the counter at CREDITS and sets credit_err. credit_err clears only on reset.
- Credits at zero: the channel is skipped by arbitration. A return raises eligibility on the following cycle, not the same cycle.
- No eligible channel in the accept window: no rdy asserted, pointer unchanged.
- val dropped while not granted is legal. The flit is captured only on the handshake edge.

Test Plan:
- Single flit: reset, val_1 with network_out_1=64'h1111_2222_3333_4444 -> rdy_1 high 1 cycle; next cycles show data 32'h11112222/ch 01, then 32'h33334444/ch 01, then 0/ch 00; credit_1=7.
- Round-robin: all three val held high, CREDITS=8 -> grant order 1,2,3,1,2,3; beats contiguous at 2 cycles/flit; no rdy overlap.
- Credit exhaustion: only val_2 high, no returns -> exactly 8 flits sent, then rdy_2 stays low. One credit_back_out=3'b010 pulse -> exactly one more flit, starting its beat 2 cycles after the pulse.
- Simultaneous: credit_2 at 5, handshake on channel 2 and credit_back_out[1] pulse in the same cycle -> credit_2 stays 5.
- Overflow: credit_back_out=3'b100 pulse at reset state -> credit_3 stays 8, credit_err=1 and stays 1 until rst_n low.
- Reset mid-flit: assert rst_n low during SEND_HI -> outputs 0/00 immediately. After release, channel 1 is granted first and credits are back at 8.
